router_pkt_tx: RTL

Packet transmitter for the 1x3 router input port. It accepts a command (destination, length), buffers the full payload from an upstream byte stream, then drives the router's packet protocol. The protocol is a header byte, the payload bytes with `pkt_valid` high, then a parity byte with `pkt_valid` low. The block honours the router's `busy` back-pressure and collects the router's parity `err` result. It sits between a traffic source (bench or on-chip generator) and the router top.

---
 rtl/router_pkt_tx_if.sv | 41 ++++
 rtl/router_pkt_tx.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_tx_if.sv
// -----------------------------------------------------------------------------
// router_pkt_tx_if
//   Bundles the command, payload-source and router-side signals of
//   router_pkt_tx.
//
//   master : traffic source / environment side (drives command, payload,
//            busy and err; observes everything the transmitter produces)
//   slave  : the transmitter itself
//
//   Command : start, dest[1:0], len[5:0] -> cmd_ready, cmd_rej, done, err_flag
//   Payload : pl_data[7:0], pl_valid     -> pl_ready
//   Router  : busy, err                  -> data_out[7:0], pkt_valid
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface router_pkt_tx_if;
   logic       start;
   logic [1:0] dest;
   logic [5:0] len;
   logic [7:0] pl_data;
   logic       pl_valid;
   logic       pl_ready;
   logic       busy;
   logic       err;
   logic [7:0] data_out;
   logic       pkt_valid;
   logic       cmd_ready;
   logic       cmd_rej;
   logic       done;
   logic       err_flag;

   modport master (
      output start, dest, len, pl_data, pl_valid, busy, err,
      input  pl_ready, data_out, pkt_valid, cmd_ready, cmd_rej, done, err_flag
   );

   modport slave (
      input  start, dest, len, pl_data, pl_valid, busy, err,
      output pl_ready, data_out, pkt_valid, cmd_ready, cmd_rej, done, err_flag
   );
endinterface

// File: rtl/router_pkt_tx.sv
// -----------------------------------------------------------------------------
// router_pkt_tx
//   Packet transmitter for the 1x3 router input port. A command (dest, len) is
//   accepted while idle, the whole payload is buffered from the upstream byte
//   stream, then the packet is sent as header {len,dest}, payload bytes with
//   pkt_valid high, and an XOR parity byte with pkt_valid low. The router's
//   busy holds the current byte; its err line is sampled for ERR_WAIT cycles
//   after the parity byte and folded into a sticky err_flag.
//
//   Parameters : ERR_WAIT - cycles spent sampling err before done
//                MAX_LEN  - payload buffer depth (6-bit length field)
//   Ports      : clk  - clock
//                rst  - synchronous, active-low reset
//                bus  - router_pkt_tx_if.slave (command, payload, router side)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module router_pkt_tx #(
   parameter int ERR_WAIT = 3,
   parameter int MAX_LEN  = 63
) (
   input  logic           clk,
   input  logic           rst,
   router_pkt_tx_if.slave bus
);

   localparam int CNT_W = (ERR_WAIT < 2) ? 1 : $clog2(ERR_WAIT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_HEADER,
      S_PAYLOAD,
      S_PARITY,
      S_WAIT_ERR
   } state_t;

   state_t           state, state_next;

   logic [1:0]       dest_q;
   logic [5:0]       len_q;
   logic [7:0]       parity_q;
   logic [5:0]       wr_ptr, rd_ptr;
   logic [CNT_W-1:0] cnt;
   logic             cmd_rej_q, done_q, err_flag_q;
   logic [7:0]       pl_buf [MAX_LEN];

   // Per-cycle strobes decoded from the current state and inputs
   logic             cmd_legal;
   logic             accept, reject, fill_hs;
   logic             hdr_go, pay_go, par_go, wait_end;

   // Router-facing and handshake outputs, decoded from registered state only
   logic [7:0]       data_out_c;
   logic             pkt_valid_c, pl_ready_c, cmd_ready_c;

   assign cmd_legal = (bus.dest != 2'd3) && (bus.len != 6'd0);

   // State register
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values, independent of statement order.
      if (!rst) state <= S_IDLE;
      else      state <= state_next;
   end

   // Next-state and output decode
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // it unassigned, which would otherwise infer a latch.
      state_next  = state;
      accept      = 1'b0;
      reject      = 1'b0;
      fill_hs     = 1'b0;
      hdr_go      = 1'b0;
      pay_go      = 1'b0;
      par_go      = 1'b0;
      wait_end    = 1'b0;
      data_out_c  = 8'h00;
      pkt_valid_c = 1'b0;
      pl_ready_c  = 1'b0;
      cmd_ready_c = 1'b0;

      unique case (state)
         S_IDLE: begin
            cmd_ready_c = 1'b1;
            if (bus.start) begin
               if (cmd_legal) begin
                  accept     = 1'b1;
                  state_next = S_FILL;
               end else begin
                  reject = 1'b1;
               end
            end
         end
         S_FILL: begin
            pl_ready_c = 1'b1;
            if (bus.pl_valid) begin
               fill_hs = 1'b1;
               if (wr_ptr == len_q - 6'd1) state_next = S_HEADER;
            end
         end
         S_HEADER: begin
            data_out_c  = {len_q, dest_q};
            pkt_valid_c = 1'b1;
            if (!bus.busy) begin
               hdr_go     = 1'b1;
               state_next = S_PAYLOAD;
            end
         end
         S_PAYLOAD: begin
            data_out_c  = pl_buf[rd_ptr];
            pkt_valid_c = 1'b1;
            if (!bus.busy) begin
               pay_go = 1'b1;
               if (rd_ptr == len_q - 6'd1) state_next = S_PARITY;
            end
         end
         S_PARITY: begin
            data_out_c = parity_q;
            if (!bus.busy) begin
               par_go     = 1'b1;
               state_next = S_WAIT_ERR;
            end
         end
         S_WAIT_ERR: begin
            if (cnt == CNT_W'(1)) begin
               wait_end   = 1'b1;
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Command latch, pointers, parity, err window and registered pulses
   always_ff @(posedge clk) begin
      if (!rst) begin
         dest_q     <= 2'd0;
         len_q      <= 6'd0;
         parity_q   <= 8'h00;
         wr_ptr     <= 6'd0;
         rd_ptr     <= 6'd0;
         cnt        <= '0;
         cmd_rej_q  <= 1'b0;
         done_q     <= 1'b0;
         err_flag_q <= 1'b0;
      end else begin
         cmd_rej_q <= reject;
         done_q    <= wait_end;

         if (accept) begin
            dest_q     <= bus.dest;
            len_q      <= bus.len;
            parity_q   <= {bus.len, bus.dest};   // parity starts from the header
            err_flag_q <= 1'b0;
            wr_ptr     <= 6'd0;
         end

         if (fill_hs) begin
            parity_q <= parity_q ^ bus.pl_data;
            wr_ptr   <= wr_ptr + 6'd1;
         end

         if (hdr_go) rd_ptr <= 6'd0;
         if (pay_go) rd_ptr <= rd_ptr + 6'd1;
         if (par_go) cnt    <= CNT_W'(ERR_WAIT);

         if (state == S_WAIT_ERR) begin
            err_flag_q <= err_flag_q | bus.err;
            cnt        <= cnt - CNT_W'(1);
         end
      end
   end

   // Payload buffer
   always_ff @(posedge clk) begin
      // NOTE: the buffer has no reset; every byte is rewritten during FILL
      // before it can be read, so stale contents are never observed.
      if (fill_hs) pl_buf[wr_ptr] <= bus.pl_data;
   end

   assign bus.data_out  = data_out_c;
   assign bus.pkt_valid = pkt_valid_c;
   assign bus.pl_ready  = pl_ready_c;
   assign bus.cmd_ready = cmd_ready_c;
   assign bus.cmd_rej   = cmd_rej_q;
   assign bus.done      = done_q;
   assign bus.err_flag  = err_flag_q;

endmodule
